// File: rtl/spi_pkg.sv
// Shared types, constants and the CRC7 helper for the mode-3 SPI byte responder.
package spi_pkg;

    localparam int         SPI_BYTE_W    = 8;
    localparam logic [6:0] SPI_CRC7_POLY = 7'h09;

    // Mode 3: TX bits advance on the SCK fall, RX bits are sampled on the SCK rise.
    localparam logic SPI_TX_ON_FALL = 1'b1;
    localparam logic SPI_RX_ON_RISE = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [SPI_BYTE_W-1:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = SPI_BYTE_W - 1; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ SPI_CRC7_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer followed by a previous-value flop that yields one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   level;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_byte.sv
// Mode-3 SPI byte responder oversampled in the MasterCLK domain.
// Optional RX CRC7 accumulator enabled by defining SPI_SLAVE_CRC7_EN.
//
// state     | meaning
// ST_IDLE   | CS deasserted; MISO released, SCK edges ignored
// ST_ACTIVE | CS asserted; shifting bytes on SCK edges
module spi_slave_byte
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic                  MasterCLK,
    input  logic                  Reset_n,
    input  logic                  SPI_CLK,
    input  logic                  SPI_CS_n,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    output logic                  SPI_MISO_OE,
    input  logic [SPI_BYTE_W-1:0] TxData,
    input  logic                  TxValid,
    output logic                  TxReady,
    output logic [SPI_BYTE_W-1:0] RxData,
    output logic                  RxValid,
    output logic                  TxUnderrun,
    output logic                  Busy,
    output logic [6:0]            RxCRC7
);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic tx_edge, rx_edge, mosi_bit, capture, load;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
        .clk(MasterCLK), .rst_n(Reset_n), .din(SPI_CLK), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(MasterCLK), .rst_n(Reset_n), .din(SPI_CS_n), .rise(cs_rise), .fall(cs_fall)
    );

    // Same depth as the SCK path so the sampled bit lines up with the rise event.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    spi_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  reload_pend_q, reload_pend_d;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic [SPI_BYTE_W-1:0] rx_byte;
`ifdef SPI_SLAVE_CRC7_EN
    logic [6:0]            crc_q, crc_d;
`endif

    assign tx_edge  = SPI_TX_ON_FALL ? sck_fall : sck_rise;
    assign rx_edge  = SPI_RX_ON_RISE ? sck_rise : sck_fall;
    assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];
    assign capture  = TxValid & ~hold_full_q;
    assign rx_byte  = {rx_shift_q[SPI_BYTE_W-2:0], mosi_bit};

    always_comb begin
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        reload_pend_d = reload_pend_q;
        miso_d        = miso_q;
        oe_d          = oe_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        underrun_d    = 1'b0;
        load          = 1'b0;
`ifdef SPI_SLAVE_CRC7_EN
        crc_d         = crc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d       = ST_ACTIVE;
                    bit_cnt_d     = 3'd0;
                    oe_d          = 1'b1;
                    reload_pend_d = 1'b0;
                    load          = 1'b1;
`ifdef SPI_SLAVE_CRC7_EN
                    crc_d         = 7'd0;
`endif
                end
            end
            ST_ACTIVE: begin
                if (tx_edge) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b1};
                        miso_d     = tx_shift_q[SPI_BYTE_W-2];
                    end else if (reload_pend_q) begin
                        load          = 1'b1;
                        reload_pend_d = 1'b0;
                    end
                end
                if (rx_edge) begin
                    rx_shift_d = rx_byte;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d     = rx_byte;
                        rx_valid_d    = 1'b1;
                        reload_pend_d = 1'b1;
`ifdef SPI_SLAVE_CRC7_EN
                        crc_d         = crc7_byte(crc_q, rx_byte);
`endif
                    end
                end
                // CS release wins over any shift; a byte completing this cycle is still delivered.
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    bit_cnt_d     = 3'd0;
                    oe_d          = 1'b0;
                    miso_d        = 1'b1;
                    rx_shift_d    = '1;
                    tx_shift_d    = '1;
                    reload_pend_d = 1'b0;
                    load          = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d = hold_q;
                miso_d     = hold_q[SPI_BYTE_W-1];
            end else begin
                tx_shift_d = IDLE_BYTE;
                miso_d     = IDLE_BYTE[SPI_BYTE_W-1];
                underrun_d = 1'b1;
            end
            hold_full_d = 1'b0;
        end
        if (capture) begin
            hold_d      = TxData;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            mosi_sync_q   <= '1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            tx_shift_q    <= '1;
            rx_shift_q    <= '1;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            reload_pend_q <= 1'b0;
            miso_q        <= 1'b1;
            oe_q          <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
`ifdef SPI_SLAVE_CRC7_EN
            crc_q         <= 7'd0;
`endif
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            reload_pend_q <= reload_pend_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            underrun_q    <= underrun_d;
`ifdef SPI_SLAVE_CRC7_EN
            crc_q         <= crc_d;
`endif
        end
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_OE = oe_q;
    assign TxReady     = ~hold_full_q;
    assign RxData      = rx_data_q;
    assign RxValid     = rx_valid_q;
    assign TxUnderrun  = underrun_q;
    assign Busy        = (state_q == ST_ACTIVE);
`ifdef SPI_SLAVE_CRC7_EN
    assign RxCRC7      = crc_q;
`else
    assign RxCRC7      = 7'd0;
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: vector table of single-byte transfers plus multi-cycle corner sequences.
module tb_spi_slave_byte;

    logic       MasterCLK = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       SPI_CLK   = 1'b1;
    logic       SPI_CS_n  = 1'b1;
    logic       SPI_MOSI  = 1'b1;
    logic       SPI_MISO, SPI_MISO_OE;
    logic [7:0] TxData    = 8'h00;
    logic       TxValid   = 1'b0;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxValid, TxUnderrun, Busy;
    logic [6:0] RxCRC7;

    spi_slave_byte dut (
        .MasterCLK(MasterCLK), .Reset_n(Reset_n),
        .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid), .TxUnderrun(TxUnderrun),
        .Busy(Busy), .RxCRC7(RxCRC7)
    );

    always #5 MasterCLK = ~MasterCLK;

    int         errors = 0;
    int         checks = 0;
    int         rx_cnt = 0;
    int         ur_cnt = 0;
    logic [7:0] rx_log[$];

    always @(negedge MasterCLK) begin
        if (RxValid) begin
            rx_cnt++;
            rx_log.push_back(RxData);
        end
        if (TxUnderrun) ur_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge MasterCLK);
    endtask

    // Present a byte until the handshake completes; called at a negedge.
    task automatic offer(input logic [7:0] b);
        int n;
        n = 0;
        TxData  = b;
        TxValid = 1'b1;
        while (!TxReady && n < 2000) begin
            @(negedge MasterCLK);
            n++;
        end
        if (n >= 2000) chk("offer_timeout", 32'd1, 32'd0);
        @(negedge MasterCLK);
        TxValid = 1'b0;
    endtask

    task automatic sck_bit(input logic mb, output logic sb);
        SPI_CLK  = 1'b0;
        SPI_MOSI = mb;
        wait_clk(4);
        SPI_CLK  = 1'b1;
        sb       = SPI_MISO;
        wait_clk(4);
    endtask

    task automatic xfer(input logic [7:0] mo, output logic [7:0] mi);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            sck_bit(mo[i], b);
            mi[i] = b;
        end
    endtask

    task automatic cs_low();
        SPI_CS_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        SPI_CS_n = 1'b1;
        wait_clk(6);
    endtask

    typedef struct {
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_ur;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] got;
    logic [7:0] got_b[3];
    logic [6:0] crc_exp;
    logic       bit_s;
    int         r0, u0, base;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h96, 8'hFF, 8'h96, 1};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h81, 8'h00, 8'h81, 8'h00, 0};
        vecs[4] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 0};
`ifdef SPI_SLAVE_CRC7_EN
        crc_exp = 7'h4A;
`else
        crc_exp = 7'h00;
`endif

        wait_clk(3);
        chk("rst_miso", SPI_MISO, 1);
        chk("rst_oe", SPI_MISO_OE, 0);
        chk("rst_txready", TxReady, 1);
        chk("rst_rxdata", RxData, 0);
        chk("rst_rxvalid", RxValid, 0);
        chk("rst_underrun", TxUnderrun, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_crc", RxCRC7, 0);
        Reset_n = 1'b1;
        wait_clk(4);

        for (int v = 0; v < 5; v++) begin
            r0 = rx_cnt;
            u0 = ur_cnt;
            if (vecs[v].load) begin
                offer(vecs[v].tx);
                chk("vec_txready_full", TxReady, 0);
            end
            cs_low();
            chk("vec_busy", Busy, 1);
            chk("vec_oe_on", SPI_MISO_OE, 1);
            chk("vec_txready_after_load", TxReady, 1);
            xfer(vecs[v].mosi, got);
            cs_high();
            chk("vec_miso", got, vecs[v].exp_miso);
            chk("vec_rxdata", RxData, vecs[v].exp_rx);
            chk("vec_rxvalid_count", rx_cnt - r0, 1);
            chk("vec_underrun_count", ur_cnt - u0, vecs[v].exp_ur);
            chk("vec_oe_off", SPI_MISO_OE, 0);
            chk("vec_busy_off", Busy, 0);
        end

        // 3-byte burst with the next byte offered as soon as the holding register frees up
        r0   = rx_cnt;
        u0   = ur_cnt;
        base = rx_log.size();
        offer(8'h11);
        fork
            begin
                offer(8'h22);
                offer(8'h33);
            end
            begin
                cs_low();
                xfer(8'h01, got_b[0]);
                xfer(8'h02, got_b[1]);
                xfer(8'h03, got_b[2]);
                cs_high();
            end
        join
        chk("burst_miso0", got_b[0], 8'h11);
        chk("burst_miso1", got_b[1], 8'h22);
        chk("burst_miso2", got_b[2], 8'h33);
        chk("burst_rx_count", rx_cnt - r0, 3);
        chk("burst_underrun", ur_cnt - u0, 0);
        if (rx_log.size() >= base + 3) begin
            chk("burst_rx0", rx_log[base], 8'h01);
            chk("burst_rx1", rx_log[base+1], 8'h02);
            chk("burst_rx2", rx_log[base+2], 8'h03);
        end else begin
            chk("burst_rx_log_size", rx_log.size() - base, 3);
        end

        // CS released after five rises: partial byte dropped, then a clean byte
        r0 = rx_cnt;
        cs_low();
        for (int i = 0; i < 5; i++) sck_bit(1'b1, bit_s);
        SPI_CS_n = 1'b1;
        wait_clk(4);
        chk("abort_oe", SPI_MISO_OE, 0);
        chk("abort_miso", SPI_MISO, 1);
        chk("abort_busy", Busy, 0);
        wait_clk(4);
        chk("abort_no_rxvalid", rx_cnt - r0, 0);
        offer(8'h96);
        cs_low();
        xfer(8'hC3, got);
        cs_high();
        chk("after_abort_miso", got, 8'h96);
        chk("after_abort_rx", RxData, 8'hC3);
        chk("after_abort_rx_count", rx_cnt - r0, 1);

        // CS rises together with the 8th SCK rise: byte still completes
        r0 = rx_cnt;
        offer(8'hE7);
        cs_low();
        for (int i = 7; i >= 1; i--) begin
            sck_bit(((8'h6B >> i) & 8'h01) != 8'h00, bit_s);
            got[i] = bit_s;
        end
        SPI_CLK  = 1'b0;
        SPI_MOSI = 1'b1;
        wait_clk(4);
        SPI_CLK  = 1'b1;
        SPI_CS_n = 1'b1;
        got[0]   = SPI_MISO;
        wait_clk(6);
        chk("coinc_miso", got, 8'hE7);
        chk("coinc_rx", RxData, 8'h6B);
        chk("coinc_rx_count", rx_cnt - r0, 1);
        chk("coinc_oe", SPI_MISO_OE, 0);

        // Reset mid-byte with a byte waiting in holding
        offer(8'h77);
        cs_low();
        for (int i = 0; i < 3; i++) sck_bit(1'b0, bit_s);
        offer(8'h55);
        chk("prerst_txready", TxReady, 0);
        u0 = ur_cnt;
        r0 = rx_cnt;
        Reset_n  = 1'b0;
        SPI_CS_n = 1'b1;
        SPI_CLK  = 1'b1;
        wait_clk(2);
        chk("midrst_miso", SPI_MISO, 1);
        chk("midrst_oe", SPI_MISO_OE, 0);
        chk("midrst_txready", TxReady, 1);
        chk("midrst_rxdata", RxData, 0);
        chk("midrst_rxvalid", RxValid, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_underrun", TxUnderrun, 0);
        Reset_n = 1'b1;
        wait_clk(4);
        chk("midrst_no_pulses", (rx_cnt - r0) + (ur_cnt - u0), 0);
        cs_low();
        xfer(8'h12, got);
        cs_high();
        chk("postrst_miso", got, 8'hFF);
        chk("postrst_underrun", ur_cnt - u0, 1);
        chk("postrst_rx", RxData, 8'h12);

        // CMD0 frame: CRC7 over 40 00 00 00 00, then cleared by the next CS fall
        r0 = rx_cnt;
        cs_low();
        xfer(8'h40, got);
        for (int i = 0; i < 4; i++) xfer(8'h00, got);
        wait_clk(2);
        chk("crc_rx_count", rx_cnt - r0, 5);
        chk("crc_cmd0", RxCRC7, crc_exp);
        cs_high();
        chk("crc_held_idle", RxCRC7, crc_exp);
        cs_low();
        chk("crc_cleared", RxCRC7, 0);
        cs_high();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
